ctech_lib_clk_divider_prog: RTL
===============================

CTECH_LIB_CLK_DIVIDER_PROG -- requirements
Module: ctech_lib_clk_divider_prog

Interface
REQ-001 SHALL have parameter DIV_W, default 4: width of the divide-ratio field.
REQ-002 SHALL have parameter DEF_RATIO, default 2: divide ratio loaded at reset (2..2^DIV_W-1).
REQ-003 SHALL have port clk, input, 1: the single source clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1: divider run enable.
REQ-006 SHALL have port div_ratio, input, DIV_W: requested divide ratio N.
REQ-007 SHALL have port div_load, input, 1: one-cycle strobe capturing div_ratio as the pending ratio.
REQ-008 SHALL have port clkout, output, 1: divided clock, driven directly from a flop.
REQ-009 SHALL have port clkout_rise, output, 1: one-cycle strobe, high in the first clk cycle of each clkout high phase.
REQ-010 SHALL have port ratio_upd, output, 1: one-cycle strobe, high in the cycle a pending ratio becomes active.
REQ-011 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, HIGH, LOW, with a down-counter of DIV_W bits.
REQ-013 SHALL clamp any active ratio N<2 (0 or 1) to 2; no bypass path and no combinational path from clk to clkout.
REQ-014 SHALL drive clkout high for H=ceil(N/2) cycles, then low for L=floor(N/2) cycles; period exactly N clk cycles; 50% duty for even N.
REQ-015 IDLE -> HIGH when en=1 is sampled; clkout=1 from the next cycle, with clkout_rise=1 in that cycle.
REQ-016 HIGH -> LOW after H cycles; LOW -> HIGH after L cycles if en=1 at the final LOW cycle, else LOW -> IDLE, with clkout held 0.
REQ-017 SHALL complete the current period when en deasserts mid-period; no truncated high or low phase.
REQ-018 div_load SHALL latch div_ratio into the pending register and set the pending flag; when several loads occur before a boundary, the last one wins.
REQ-019 The pending ratio SHALL become active only at a period boundary (the LOW->HIGH or IDLE->HIGH transition), with ratio_upd=1 in the first HIGH cycle of the new period.
REQ-020 When div_load coincides with the boundary-decision cycle, the newly presented value SHALL be used for the period that follows.
REQ-021 A div_load in IDLE SHALL update the active ratio at the next IDLE->HIGH transition, with ratio_upd pulsing then.
REQ-022 Loading a value equal to the active ratio SHALL still pulse ratio_upd.
REQ-023 busy SHALL be 1 in HIGH and LOW, and 0 in IDLE.

Reset
REQ-024 When rst=1, the next cycle SHALL give: state IDLE, clkout=0, clkout_rise=0, ratio_upd=0, busy=0, active ratio=DEF_RATIO, pending flag cleared, counter 0.
REQ-025 rst SHALL override en and div_load in the same cycle.
REQ-026 A reset mid-period SHALL abort immediately with clkout forced low; the period is not completed.

Verification
REQ-027 rst, then en=1 with DEF_RATIO=2 -> clkout toggles 1,0,1,0...; clkout_rise every 2nd cycle; busy=1.
REQ-028 Load N=5 while running at N=2 -> current period finishes; then clkout high 3, low 2 cycles; ratio_upd pulses once in the first high cycle.
REQ-029 Load N=0 or N=1 -> output behaves as N=2.
REQ-030 At N=6, drop en in the 2nd HIGH cycle -> 1 more high cycle, 3 low cycles, then IDLE with clkout=0 and busy=0.
REQ-031 Loads of 7 and then 4 within one period -> the next period uses 4 (high 2, low 2); ratio_upd pulses once.
REQ-032 Assert rst in a HIGH cycle at N=7 -> clkout=0 the next cycle, then IDLE, and the active ratio returns to DEF_RATIO.

Source files
------------

// File: rtl/ctech_lib_clk_divider_prog.sv
// ctech_lib_clk_divider_prog
//   Programmable integer clock divider. clkout runs high for ceil(N/2) and
//   low for floor(N/2) cycles of clk, so the period is exactly N cycles.
//   A new ratio is staged through a pending register and only takes effect
//   at a period boundary, so no high or low phase is ever truncated. The
//   only exception is reset, which aborts the current period.
//
// Ports
//   clk         source clock; all state changes on its rising edge
//   rst         synchronous active-high reset; overrides en and div_load
//   en          run enable; checked at IDLE and at the last LOW cycle
//   div_ratio   requested divide ratio N (values 0 and 1 act as 2)
//   div_load    one-cycle strobe; stages div_ratio as the pending ratio
//   clkout      divided clock, taken straight from a flop
//   clkout_rise high in the first cycle of each clkout high phase
//   ratio_upd   high in the first HIGH cycle that uses a newly loaded ratio
//   busy        high while a period is in progress (state HIGH or LOW)
module ctech_lib_clk_divider_prog #(
  parameter int DIV_W     = 4,
  parameter int DEF_RATIO = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_load,
  output logic             clkout,
  output logic             clkout_rise,
  output logic             ratio_upd,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // The active ratio is always held in clamped form (>= 2).
  localparam logic [DIV_W-1:0] DEF_R = (DEF_RATIO < 2) ? DIV_W'(2) : DIV_W'(DEF_RATIO);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] pend_ratio_q, pend_ratio_d;
  logic             pend_q, pend_d;
  logic             clkout_d, rise_d, upd_d;

  logic [DIV_W-1:0] next_raw, next_ratio, hi_cnt, lo_cnt;
  logic             next_upd, start;

  // Ratio for a period starting now: a load in this very cycle wins over
  // an older pending value, which wins over the current active ratio.
  always_comb begin
    next_raw   = div_load ? div_ratio : (pend_q ? pend_ratio_q : ratio_q);
    next_ratio = (next_raw < DIV_W'(2)) ? DIV_W'(2) : next_raw;
    next_upd   = div_load | pend_q;
    // Counter reload values are phase length minus one:
    // ceil(N/2)-1 == floor((N-1)/2), and floor(N/2)-1.
    hi_cnt     = (next_ratio - DIV_W'(1)) >> 1;
    lo_cnt     = (ratio_q >> 1) - DIV_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ratio_d      = ratio_q;
    pend_d       = pend_q;
    pend_ratio_d = pend_ratio_q;
    clkout_d     = 1'b0;
    rise_d       = 1'b0;
    upd_d        = 1'b0;
    start        = 1'b0;

    if (div_load) begin
      pend_d       = 1'b1;
      pend_ratio_d = div_ratio;
    end

    case (state_q)
      IDLE: start = en;
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = lo_cnt;
        end else begin
          cnt_d    = cnt_q - DIV_W'(1);
          clkout_d = 1'b1;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          if (en) start = 1'b1;
          else    state_d = IDLE;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Period boundary: adopt the staged ratio and open a new high phase.
    if (start) begin
      state_d  = HIGH;
      cnt_d    = hi_cnt;
      ratio_d  = next_ratio;
      pend_d   = 1'b0;
      clkout_d = 1'b1;
      rise_d   = 1'b1;
      upd_d    = next_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ratio_q      <= DEF_R;
      pend_q       <= 1'b0;
      pend_ratio_q <= '0;
      clkout       <= 1'b0;
      clkout_rise  <= 1'b0;
      ratio_upd    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ratio_q      <= ratio_d;
      pend_q       <= pend_d;
      pend_ratio_q <= pend_ratio_d;
      clkout       <= clkout_d;
      clkout_rise  <= rise_d;
      ratio_upd    <= upd_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
